// File: rtl/rs_retire_collector_if.sv
// Retire-path bus between the execute lanes and the scheduler clear ports.
// The collector uses the slave modport. The execute/scheduler side uses master.
interface rs_retire_collector_if #(
  parameter int RS_ENTRIES = 16,
  parameter int N_EX       = 3,
  parameter int CLR_PORTS  = 2
);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic [N_EX-1:0]            ex_retire_valid;
  logic [N_EX*IDX_W-1:0]      ex_retire_entry;
  logic                       ex_ready;
  logic [CLR_PORTS-1:0]       sch_clr_valid;
  logic [CLR_PORTS*IDX_W-1:0] sch_clr_entry;

  modport master (
    output ex_retire_valid,
    output ex_retire_entry,
    input  ex_ready,
    input  sch_clr_valid,
    input  sch_clr_entry
  );

  modport slave (
    input  ex_retire_valid,
    input  ex_retire_entry,
    output ex_ready,
    output sch_clr_valid,
    output sch_clr_entry
  );
endinterface

// File: rtl/rs_retire_collector.sv
// rs_retire_collector: gathers RS-entry retire requests from N_EX execute lanes,
// buffers the overflow in an in-order FIFO, and drives up to CLR_PORTS registered
// scheduler clear ports per cycle. Oldest request always lands on port 0.
// Optional feature macro: RS_RETIRE_DUP_CHECK_EN (pending bitmap + duplicate drop).
module rs_retire_collector #(
  parameter int RS_ENTRIES = 16,
  parameter int N_EX       = 3,
  parameter int CLR_PORTS  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_flush,
  rs_retire_collector_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count,
  output logic                            o_protocol_err,
  output logic                            o_dup_err
);
  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [IDX_W-1:0]                r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                r_rdPtr;
  logic [PTR_W-1:0]                r_wrPtr;
  logic [CNT_W-1:0]                r_count;
  logic [CLR_PORTS-1:0]            r_clrValid;
  logic [CLR_PORTS-1:0][IDX_W-1:0] r_clrEntry;
  logic                            r_protocolErr;

  logic                            w_exReady;
  logic [N_EX-1:0][IDX_W-1:0]      w_laneEntry;
  logic [N_EX-1:0]                 w_accept;
  logic [N_EX-1:0][IDX_W-1:0]      w_accEntry;
  int                              w_nAcc;
  int                              w_nPop;
  int                              w_nIssue;
  int                              w_nLaneIssue;
  int                              w_nPush;
  logic [CLR_PORTS-1:0]            w_portValid;
  logic [CLR_PORTS-1:0][IDX_W-1:0] w_portEntry;

`ifdef RS_RETIRE_DUP_CHECK_EN
  logic [RS_ENTRIES-1:0]           r_pending;
  logic                            r_dupErr;
  logic                            w_dupHit;
  logic [RS_ENTRIES-1:0]           w_setMask;
  logic [RS_ENTRIES-1:0]           w_clrMask;
`endif

  // Lanes may only present requests when the FIFO can absorb a full set of lanes.
  assign w_exReady   = (FIFO_DEPTH - int'(r_count)) >= N_EX;
  assign w_laneEntry = bus.ex_retire_entry;

  // Decide which lanes are accepted this cycle; duplicates lose to the older copy.
  always_comb begin
    w_accept = '0;
`ifdef RS_RETIRE_DUP_CHECK_EN
    w_dupHit = 1'b0;
`endif
    for (int i = 0; i < N_EX; i++) begin
      if (bus.ex_retire_valid[i] && w_exReady && !i_flush) begin
        w_accept[i] = 1'b1;
`ifdef RS_RETIRE_DUP_CHECK_EN
        if (r_pending[w_laneEntry[i]]) w_accept[i] = 1'b0;
        for (int j = 0; j < i; j++) begin
          if (bus.ex_retire_valid[j] && (w_laneEntry[j] == w_laneEntry[i])) w_accept[i] = 1'b0;
        end
        if (!w_accept[i]) w_dupHit = 1'b1;
`endif
      end
    end
  end

  // Pack accepted lanes, then fill clear ports FIFO-first and split the rest into pushes.
  always_comb begin
    w_nAcc     = 0;
    w_accEntry = '0;
    for (int i = 0; i < N_EX; i++) begin
      if (w_accept[i]) begin
        w_accEntry[w_nAcc] = w_laneEntry[i];
        w_nAcc = w_nAcc + 1;
      end
    end
    w_nPop       = (int'(r_count) < CLR_PORTS) ? int'(r_count) : CLR_PORTS;
    w_nIssue     = ((int'(r_count) + w_nAcc) < CLR_PORTS) ? (int'(r_count) + w_nAcc) : CLR_PORTS;
    w_nLaneIssue = w_nIssue - w_nPop;
    w_nPush      = w_nAcc - w_nLaneIssue;
    w_portValid  = '0;
    w_portEntry  = '0;
    for (int p = 0; p < CLR_PORTS; p++) begin
      if (p < w_nPop) begin
        w_portValid[p] = 1'b1;
        w_portEntry[p] = r_mem[PTR_W'(int'(r_rdPtr) + p)];
      end else if (p < w_nIssue) begin
        w_portValid[p] = 1'b1;
        w_portEntry[p] = w_accEntry[p - w_nPop];
      end
    end
  end

  // Pointer, count, clear-port and sticky-error state; flush overrides normal updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_count       <= '0;
      r_clrValid    <= '0;
      r_clrEntry    <= '0;
      r_protocolErr <= 1'b0;
    end else if (i_flush) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_clrValid <= '0;
    end else begin
      r_rdPtr <= PTR_W'(int'(r_rdPtr) + w_nPop);
      r_wrPtr <= PTR_W'(int'(r_wrPtr) + w_nPush);
      r_count <= CNT_W'(int'(r_count) - w_nPop + w_nPush);
      for (int p = 0; p < CLR_PORTS; p++) begin
        r_clrValid[p] <= w_portValid[p];
        if (w_portValid[p]) r_clrEntry[p] <= w_portEntry[p];
      end
      if ((|bus.ex_retire_valid) && !w_exReady) r_protocolErr <= 1'b1;
    end
  end

  // FIFO storage: accepted lanes that did not get a clear port are written in lane order.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush) begin
      for (int k = 0; k < N_EX; k++) begin
        if ((k >= w_nLaneIssue) && (k < w_nAcc)) begin
          r_mem[PTR_W'(int'(r_wrPtr) + k - w_nLaneIssue)] <= w_accEntry[k];
        end
      end
    end
  end

`ifdef RS_RETIRE_DUP_CHECK_EN
  // Bitmap updates: entries become pending on accept and leave when sent to a clear port.
  always_comb begin
    w_setMask = '0;
    w_clrMask = '0;
    for (int k = 0; k < N_EX; k++) begin
      if (k < w_nAcc) w_setMask[w_accEntry[k]] = 1'b1;
    end
    for (int p = 0; p < CLR_PORTS; p++) begin
      if (w_portValid[p]) w_clrMask[w_portEntry[p]] = 1'b1;
    end
  end

  // Pending bitmap and sticky duplicate flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_dupErr  <= 1'b0;
    end else if (i_flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_setMask) & ~w_clrMask;
      if (w_dupHit) r_dupErr <= 1'b1;
    end
  end

  assign o_dup_err = r_dupErr;
`else
  assign o_dup_err = 1'b0;
`endif

  assign bus.ex_ready      = w_exReady;
  assign bus.sch_clr_valid = r_clrValid;
  assign bus.sch_clr_entry = r_clrEntry;
  assign o_fifo_count      = r_count;
  assign o_protocol_err    = r_protocolErr;
endmodule

// File: tb/tb_rs_retire_collector.sv
// Testbench for rs_retire_collector. A queue-based reference model tracks the
// outstanding retires; each cycle the candidates (queue, then accepted lanes) are
// handed out CLR_PORTS at a time and the remainder stays queued.
module tb_rs_retire_collector;
  localparam int RS_ENTRIES = 16;
  localparam int N_EX       = 3;
  localparam int CLR_PORTS  = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int IDX_W      = 4;
  localparam int CNT_W      = 4;

  typedef logic [IDX_W-1:0] idx_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] fifoCount;
  logic             protocolErr;
  logic             dupErr;

  rs_retire_collector_if #(.RS_ENTRIES(RS_ENTRIES), .N_EX(N_EX), .CLR_PORTS(CLR_PORTS)) bus ();

  rs_retire_collector #(
    .RS_ENTRIES(RS_ENTRIES), .N_EX(N_EX), .CLR_PORTS(CLR_PORTS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_flush(flush),
    .bus(bus),
    .o_fifo_count(fifoCount),
    .o_protocol_err(protocolErr),
    .o_dup_err(dupErr)
  );

  always #5 clk = ~clk;

  idx_t                            modelQ[$];
  logic [CLR_PORTS-1:0]            expValid;
  logic [CLR_PORTS-1:0][IDX_W-1:0] expEntry;
  bit                              modelProt;
  bit                              modelDup;
  int                              checks   = 0;
  int                              failures = 0;

  function automatic bit modelReady();
    return (FIFO_DEPTH - modelQ.size()) >= N_EX;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    expValid  = '0;
    expEntry  = '0;
    modelProt = 1'b0;
    modelDup  = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    flush = 1'b0;
    bus.ex_retire_valid = '0;
    bus.ex_retire_entry = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of lane requests, advance the model, and step past the clock edge.
  task automatic applyStimulus(input logic [N_EX-1:0] v,
                               input logic [N_EX-1:0][IDX_W-1:0] ents,
                               input logic fl);
    idx_t cand[$];
    bit   ready;
    bit   dup;
    ready = modelReady();
    check("ready_pre", 32'(bus.ex_ready), 32'(ready));
    bus.ex_retire_valid = v;
    bus.ex_retire_entry = ents;
    flush = fl;
    if (fl) begin
      modelQ.delete();
      expValid = '0;
    end else begin
      if ((v != '0) && !ready) modelProt = 1'b1;
      cand = modelQ;
      if (ready) begin
        for (int i = 0; i < N_EX; i++) begin
          if (v[i]) begin
            dup = 1'b0;
`ifdef RS_RETIRE_DUP_CHECK_EN
            foreach (modelQ[k]) if (modelQ[k] == ents[i]) dup = 1'b1;
            for (int j = 0; j < i; j++) if (v[j] && (ents[j] == ents[i])) dup = 1'b1;
            if (dup) modelDup = 1'b1;
`endif
            if (!dup) cand.push_back(ents[i]);
          end
        end
      end
      expValid = '0;
      for (int p = 0; p < CLR_PORTS; p++) begin
        if (cand.size() > 0) begin
          expValid[p] = 1'b1;
          expEntry[p] = cand.pop_front();
        end
      end
      modelQ = cand;
    end
    @(posedge clk);
    #1;
    bus.ex_retire_valid = '0;
    flush = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".valid"},  32'(bus.sch_clr_valid), 32'(expValid));
    check({tag, ".entry"},  32'(bus.sch_clr_entry), 32'(expEntry));
    check({tag, ".count"},  32'(fifoCount),         32'(modelQ.size()));
    check({tag, ".ready"},  32'(bus.ex_ready),      32'(modelReady()));
    check({tag, ".proto"},  32'(protocolErr),       32'(modelProt));
    check({tag, ".dup"},    32'(dupErr),            32'(modelDup));
  endtask

  initial begin
    logic [N_EX-1:0]            v;
    logic [N_EX-1:0][IDX_W-1:0] ents;
    logic                       fl;
    int                         seq;

    $display("[TB] start");
    resetDut();
    checkOutput("reset");
    check("reset.ready_lit", 32'(bus.ex_ready), 32'd1);

    // single lane
    applyStimulus(3'b001, {4'd0, 4'd0, 4'd5}, 1'b0);
    checkOutput("single");
    check("single.valid_lit", 32'(bus.sch_clr_valid), 32'h1);
    check("single.entry0_lit", 32'(bus.sch_clr_entry[3:0]), 32'd5);
    check("single.count_lit", 32'(fifoCount), 32'd0);

    // burst of three lanes
    applyStimulus(3'b111, {4'd9, 4'd7, 4'd2}, 1'b0);
    checkOutput("burst1");
    check("burst1.entries_lit", 32'(bus.sch_clr_entry), 32'h72);
    applyStimulus(3'b000, '0, 1'b0);
    checkOutput("burst2");
    check("burst2.valid_lit", 32'(bus.sch_clr_valid), 32'h1);
    check("burst2.entry0_lit", 32'(bus.sch_clr_entry[3:0]), 32'd9);

    // fill until not ready, then drain in order
    seq = 0;
    for (int c = 0; c < 6; c++) begin
      for (int l = 0; l < N_EX; l++) begin
        ents[l] = idx_t'(seq);
        seq++;
      end
      applyStimulus(3'b111, ents, 1'b0);
      checkOutput("fill");
    end
    check("fill.count_lit", 32'(fifoCount), 32'd6);
    check("fill.ready_lit", 32'(bus.ex_ready), 32'd0);
    applyStimulus(3'b000, '0, 1'b0);
    checkOutput("fill_idle");
    check("fill_idle.ready_lit", 32'(bus.ex_ready), 32'd1);
    for (int c = 0; c < 6 && modelQ.size() > 0; c++) begin
      applyStimulus(3'b000, '0, 1'b0);
      checkOutput("drain");
    end

    // randomized traffic, heavy first half to exercise full FIFO and pointer wrap
    for (int n = 0; n < 400; n++) begin
      if (n < 200) v = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      else v = 3'($urandom_range(0, 7));
      if (!modelReady()) v = '0;
      ents = 12'($urandom);
      fl = ($urandom_range(0, 29) == 0);
      applyStimulus(v, ents, fl);
      checkOutput("rand");
    end

    // flush with four entries queued and lanes active
    resetDut();
    seq = 0;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < N_EX; l++) begin
        ents[l] = idx_t'(seq);
        seq++;
      end
      applyStimulus(3'b111, ents, 1'b0);
    end
    check("preflush.count_lit", 32'(fifoCount), 32'd4);
    applyStimulus(3'b111, {4'd13, 4'd14, 4'd15}, 1'b1);
    checkOutput("flush");
    check("flush.count_lit", 32'(fifoCount), 32'd0);
    check("flush.valid_lit", 32'(bus.sch_clr_valid), 32'd0);
    check("flush.proto_lit", 32'(protocolErr), 32'd0);

    // protocol violation: request while not ready
    for (int c = 0; c < 6; c++) begin
      for (int l = 0; l < N_EX; l++) begin
        ents[l] = idx_t'(seq);
        seq++;
      end
      applyStimulus(3'b111, ents, 1'b0);
    end
    check("proto.ready_lit", 32'(bus.ex_ready), 32'd0);
    applyStimulus(3'b001, {4'd0, 4'd0, 4'd11}, 1'b0);
    checkOutput("proto");
    check("proto.err_lit", 32'(protocolErr), 32'd1);
    applyStimulus(3'b000, '0, 1'b0);
    checkOutput("proto_hold");
    resetDut();
    checkOutput("proto_rst");

    // duplicate lanes in one cycle
    applyStimulus(3'b111, {4'd4, 4'd3, 4'd3}, 1'b0);
    checkOutput("dup1");
`ifdef RS_RETIRE_DUP_CHECK_EN
    check("dup1.entries_lit", 32'(bus.sch_clr_entry), 32'h43);
    check("dup1.err_lit", 32'(dupErr), 32'd1);
`else
    check("dup1.entries_lit", 32'(bus.sch_clr_entry), 32'h33);
    check("dup1.err_lit", 32'(dupErr), 32'd0);
`endif
    applyStimulus(3'b000, '0, 1'b0);
    checkOutput("dup2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
